// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-master round-robin arbiter for one stb/ack memory target,
// with a watchdog that force-terminates transfers the target never acks.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   m0_* / m1_*           master requests (stb/we/addr/dtw) and responses
//                         (ack/err/dtr); master 0 is the CPU data port
//   s_*                   shared target side (stb/we/addr/dtw out, ack/dtr in)
//   grant                 one-hot current owner, 00 when idle
//   to_flag, to_clr       sticky timeout indicator and its clear
module mem_bus_arb #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_dtw,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [31:0]   m0_dtr,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_dtw,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [31:0]   m1_dtr,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_dtw,
    input  logic          s_ack,
    input  logic [31:0]   s_dtr,
    output logic [1:0]    grant,
    output logic          to_flag,
    input  logic          to_clr
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state, state_nx, st;
    logic          last, last_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          to_flag_nx;
    logic          sel1, done, tmo;

    always_comb begin
        // Reset forces an idle view so nothing leaks out while it is held.
        st         = reset ? IDLE : state;
        state_nx   = state;
        last_nx    = last;
        cnt_nx     = cnt;
        sel1       = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        grant      = 2'b00;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_dtw      = '0;
        m0_ack     = 1'b0;
        m0_err     = 1'b0;
        m0_dtr     = '0;
        m1_ack     = 1'b0;
        m1_err     = 1'b0;
        m1_dtr     = '0;
        case (st)
            IDLE: begin
                cnt_nx = '0;
                // On contention the master not served last wins.
                if (m0_stb && (!m1_stb || last))
                    state_nx = GNT0;
                else if (m1_stb)
                    state_nx = GNT1;
            end
            GNT0, GNT1: begin
                sel1   = (st == GNT1);
                grant  = sel1 ? 2'b10 : 2'b01;
                s_stb  = sel1 ? m1_stb  : m0_stb;
                s_we   = sel1 ? m1_we   : m0_we;
                s_addr = sel1 ? m1_addr : m0_addr;
                s_dtw  = sel1 ? m1_dtw  : m0_dtw;
                done   = s_stb & s_ack;
                // A real ack in the same cycle beats the watchdog.
                tmo    = (TIMEOUT != 0) && s_stb && !s_ack
                         && (cnt == TMAX);
                if (sel1) begin
                    m1_ack = done | tmo;
                    m1_err = tmo;
                    m1_dtr = tmo ? 32'h0 : s_dtr;
                end else begin
                    m0_ack = done | tmo;
                    m0_err = tmo;
                    m0_dtr = tmo ? 32'h0 : s_dtr;
                end
                if (!s_stb) begin
                    // Master abandoned: leave priority untouched.
                    state_nx = IDLE;
                end else if (done || tmo) begin
                    state_nx = IDLE;
                    last_nx  = sel1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // A fresh timeout overrides a simultaneous clear.
        to_flag_nx = tmo ? 1'b1 : (to_clr ? 1'b0 : to_flag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            cnt     <= cnt_nx;
            to_flag <= to_flag_nx;
        end
    end

endmodule
